toggle_port_responder: RTL and testbench

- Target end of the toggle-handshake SDRAM port used by the ROM download controller: the requester flips `req` once per access, and this block flips `ack` once per completed access.
- Each access is captured into a small in-order FIFO and replayed to a level-request memory bus. That bus is a single SDRAM port slot or a BRAM wrapper.
- Lets a free-running requester (ioctl byte stream) post writes without stalling, and reports when it outruns the memory.

---
 rtl/toggle_port_pkg.sv | 20 ++
 rtl/toggle_port_fifo.sv | 47 ++++
 rtl/toggle_port_responder.sv | 103 ++++++++++
 tb/tb_toggle_port_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/toggle_port_pkg.sv
// toggle_port_pkg: shared types for the toggle-handshake port responder.
// Entry coalescing (the cnt field) exists only when TOGGLE_PORT_COALESCE_EN is defined.
package toggle_port_pkg;
  localparam int ADDR_W = 23;
  localparam int DEF_DEPTH = 4;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int PTR_W = ptr_w(DEF_DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [1:0] ds;
    logic we;
    logic [15:0] d;
`ifdef TOGGLE_PORT_COALESCE_EN
    logic [1:0] cnt;
`endif
  } entry_t;
endpackage

// File: rtl/toggle_port_fifo.sv
// toggle_port_fifo: in-order entry FIFO; with TOGGLE_PORT_COALESCE_EN it exposes a tail read/modify port.
module toggle_port_fifo
  import toggle_port_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic   clk_sys,
  input  logic   reset,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
`ifdef TOGGLE_PORT_COALESCE_EN
  input  logic   merge,
  input  entry_t merge_entry,
  output entry_t tail,
  output logic   single,
`endif
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int PW = ptr_w(DEPTH);
  entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW-2:0] ti;
  assign ti = wp[PW-2:0] - (PW-1)'(1);
  assign empty = wp == rp;
  assign full = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
  assign head = mem[rp[PW-2:0]];
`ifdef TOGGLE_PORT_COALESCE_EN
  assign tail = mem[ti];
  assign single = wp == rp + PW'(1);
`endif
  always_ff @(posedge clk_sys)
    if (push) mem[wp[PW-2:0]] <= din;
`ifdef TOGGLE_PORT_COALESCE_EN
    else if (merge) mem[ti] <= merge_entry;
`endif
  always_ff @(posedge clk_sys)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
    end
endmodule

// File: rtl/toggle_port_responder.sv
// toggle_port_responder: toggle-handshake port target replaying accesses to a level-request memory bus.
// Optional same-address write coalescing is enabled by TOGGLE_PORT_COALESCE_EN.
module toggle_port_responder
  import toggle_port_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          port_req,
  input  logic [AW-1:0] port_a,
  input  logic [1:0]    port_ds,
  input  logic          port_we,
  input  logic [15:0]   port_d,
  output logic          port_ack,
  output logic [15:0]   port_q,
  output logic          overflow,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [1:0]    mem_ds,
  output logic [15:0]   mem_d,
  input  logic          mem_done,
  input  logic [15:0]   mem_q
);
  state_t st;
  logic req_seen, req_edge, push, pop, full, empty, merge, flip;
  entry_t head, in_e;
  assign req_edge = port_req != req_seen;
  assign pop = st == IDLE && !empty;
  assign push = req_edge && !merge && (!full || pop);
  always_comb begin
    in_e = '0;
    in_e.a = ADDR_W'(port_a);
    in_e.ds = port_ds;
    in_e.we = port_we;
    in_e.d = port_d;
`ifdef TOGGLE_PORT_COALESCE_EN
    in_e.cnt = 2'd1;
`endif
  end
`ifdef TOGGLE_PORT_COALESCE_EN
  entry_t tail, merged;
  logic single;
  // A lone entry being popped this cycle is no longer the tail we may modify.
  assign merge = req_edge && port_we && !empty && tail.we && tail.a == in_e.a &&
                 (tail.ds & port_ds) == 2'b00 && !(pop && single);
  always_comb begin
    merged = tail;
    merged.ds = tail.ds | port_ds;
    merged.d = {port_ds[1] ? port_d[15:8] : tail.d[15:8], port_ds[0] ? port_d[7:0] : tail.d[7:0]};
    merged.cnt = tail.cnt + 2'd1;
  end
`else
  assign merge = 1'b0;
  assign flip = 1'b1;
`endif
  toggle_port_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys(clk_sys), .reset(reset), .push(push), .din(in_e), .pop(pop),
`ifdef TOGGLE_PORT_COALESCE_EN
    .merge(merge), .merge_entry(merged), .tail(tail), .single(single),
`endif
    .head(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk_sys)
    if (reset) begin
      st <= IDLE;
      req_seen <= port_req;
      port_ack <= port_req;
      port_q <= '0;
      overflow <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_a <= '0;
      mem_ds <= '0;
      mem_d <= '0;
`ifdef TOGGLE_PORT_COALESCE_EN
      flip <= 1'b0;
`endif
    end else begin
      if (req_edge) req_seen <= port_req;
      if (req_edge && !merge && full && !pop) overflow <= 1'b1;
      if (st == IDLE) begin
        if (!empty) begin
          st <= BUSY;
          mem_req <= 1'b1;
          mem_we <= head.we;
          mem_a <= AW'(head.a);
          mem_ds <= head.ds;
          mem_d <= head.d;
`ifdef TOGGLE_PORT_COALESCE_EN
          flip <= head.cnt[0];
`endif
        end
      end else if (mem_done) begin
        st <= IDLE;
        mem_req <= 1'b0;
        port_ack <= port_ack ^ flip;
        if (!mem_we) port_q <= mem_q;
      end
    end
endmodule

// File: tb/tb_toggle_port_responder.sv
// tb_toggle_port_responder: directed scoreboard bench for toggle_port_responder.
module tb_toggle_port_responder;
  localparam int AW = 23;
  logic clk_sys = 1'b0, reset = 1'b1, port_req = 1'b0, port_we = 1'b0, mem_done = 1'b0;
  logic [AW-1:0] port_a = '0;
  logic [1:0] port_ds = '0;
  logic [15:0] port_d = '0, mem_q = '0;
  logic port_ack, overflow, mem_req, mem_we;
  logic [15:0] port_q, mem_d;
  logic [AW-1:0] mem_a;
  logic [1:0] mem_ds;
  typedef struct {
    logic [AW-1:0] a;
    logic [1:0] ds;
    logic we;
    logic [15:0] d;
    int n;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, n_acc = 0;
  logic exp_ack = 1'b0;
  always #5 clk_sys = ~clk_sys;
  toggle_port_responder #(.AW(AW), .DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .port_req(port_req), .port_a(port_a), .port_ds(port_ds),
    .port_we(port_we), .port_d(port_d), .port_ack(port_ack), .port_q(port_q), .overflow(overflow),
    .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_ds(mem_ds), .mem_d(mem_d),
    .mem_done(mem_done), .mem_q(mem_q)
  );
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic access(input logic [AW-1:0] a, input logic [1:0] ds, input logic we,
                        input logic [15:0] d, input bit sb);
    port_a = a;
    port_ds = ds;
    port_we = we;
    port_d = d;
    port_req = ~port_req;
    if (sb) exp_q.push_back('{a, ds, we, d, 1});
    tick();
  endtask
  task automatic serve(input int dly, input logic [15:0] q);
    int n = 0;
    exp_t e;
    while (mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("mem_req_seen", mem_req, 32'd1);
    if (mem_req === 1'b1) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_a", mem_a, e.a);
        chk("mem_ds", mem_ds, e.ds);
        chk("mem_we", mem_we, e.we);
        chk("mem_d", mem_d, e.d);
        repeat (dly) begin
          tick();
          chk("mem_hold", {mem_req, mem_a}, {1'b1, e.a});
        end
        mem_q = q;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        mem_q = '0;
        n_acc++;
        exp_ack ^= e.n[0];
        chk("mem_req_drop", mem_req, 32'd0);
        chk("port_ack", port_ack, exp_ack);
        if (!e.we) chk("port_q", port_q, q);
      end
    end
  endtask
  task automatic idle_watch(input string tag);
    logic seen = 1'b0;
    repeat (10) begin
      tick();
      if (mem_req !== 1'b0) seen = 1'b1;
    end
    chk(tag, seen, 32'd0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_ack = port_req;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int base;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_mem_req", mem_req, 32'd0);
    chk("rst_port_ack", port_ack, 32'd0);
    chk("rst_overflow", overflow, 32'd0);
    chk("rst_port_q", port_q, 32'd0);
    chk("rst_mem_bus", {mem_we, mem_a, mem_ds, mem_d}, 32'd0);
    // single write: mem_req two cycles after the toggle
    access(23'h00010, 2'b01, 1'b1, 16'h00A5, 1);
    chk("latency_c1", mem_req, 32'd0);
    tick();
    chk("latency_c2", mem_req, 32'd1);
    serve(3, 16'h0);
    // read
    access(23'h1FFFF, 2'b11, 1'b0, 16'h0, 1);
    serve(1, 16'hBEEF);
    // overflow: six toggles with done withheld
    base = n_acc;
    for (int i = 0; i < 6; i++)
      access(AW'(23'h200 + i), 2'b11, 1'b1, 16'h1000 + 16'(i), i < 5);
    chk("overflow_set", overflow, 32'd1);
    for (int i = 0; i < 5; i++) serve(0, 16'h0);
    chk("overflow_count", n_acc - base, 32'd5);
    idle_watch("overflow_no_extra");
    chk("ack_ne_req", 32'(port_ack != port_req), 32'd1);
    chk("overflow_sticky", overflow, 32'd1);
    // reset while busy with two queued entries
    access(23'h300, 2'b11, 1'b1, 16'h1111, 0);
    access(23'h301, 2'b11, 1'b1, 16'h2222, 0);
    access(23'h302, 2'b11, 1'b1, 16'h3333, 0);
    chk("busy_before_reset", mem_req, 32'd1);
    do_reset();
    chk("mid_rst_mem_req", mem_req, 32'd0);
    chk("mid_rst_port_ack", port_ack, 32'd1);
    chk("mid_rst_overflow", overflow, 32'd0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    idle_watch("mid_rst_no_request");
    chk("mid_rst_ack_hold", port_ack, 32'd1);
    // simultaneous push and pop on a full FIFO
    for (int i = 0; i < 5; i++) access(AW'(23'h400 + i), 2'b10, 1'b1, 16'hA000 + 16'(i), 1);
    chk("full_no_overflow", overflow, 32'd0);
    serve(0, 16'h0);
    access(23'h405, 2'b01, 1'b1, 16'hA005, 1);
    chk("pushpop_no_overflow", overflow, 32'd0);
    access(23'h406, 2'b01, 1'b1, 16'hA006, 0);
    chk("pushpop_still_full", overflow, 32'd1);
    for (int i = 0; i < 5; i++) serve(0, 16'h0);
    idle_watch("pushpop_no_extra");
    chk("pushpop_ack", port_ack, exp_ack);
`ifdef TOGGLE_PORT_COALESCE_EN
    do_reset();
    access(23'h100, 2'b11, 1'b1, 16'h5555, 1);
    access(23'h000005, 2'b01, 1'b1, 16'h0012, 0);
    access(23'h000005, 2'b10, 1'b1, 16'h3400, 0);
    exp_q.push_back('{23'h000005, 2'b11, 1'b1, 16'h3412, 2});
    serve(1, 16'h0);
    serve(1, 16'h0);
    idle_watch("coalesce_no_extra");
    chk("coalesce_ack_eq_req", port_ack, port_req);
    chk("coalesce_overflow", overflow, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
